ldpc_iter_sched: RTL and testbench
==================================

Name: ldpc_iter_sched

Overview:
Flooding-schedule controller for the LDPC decoder datapath. It sequences the LLR load sweep, the check-node and variable-node update sweeps, and syndrome evaluation. It also counts decoding iterations and reports the decode result. It drives address/enable strobes into the message memories and takes one parity bit per check node back from the datapath.

Parameters:
- N, 204, number of variable nodes (codeword length)
- M, 102, number of check nodes
- LOG2N, 8, width of variable-node address
- LOG2M, 7, width of check-node address
- MAX_ITER, 30, maximum variable-node sweeps per codeword
- LOG2MAX_ITER, 5, width of iteration counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin decoding one codeword; sampled only in IDLE
- chk_par  in  1  parity of current hard decisions at check cn_addr; valid whenever cn_en=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is valid
- success  out  1  final syndrome was all-zero; held until next accepted start
- iter_count  out  LOG2MAX_ITER  variable-node sweeps completed; held until next accepted start
- ld_en  out  1  LLR load strobe
- ld_addr  out  LOG2N  variable node being loaded
- cn_en  out  1  check-node update strobe
- cn_addr  out  LOG2M  check node being updated
- vn_en  out  1  variable-node update strobe
- vn_addr  out  LOG2N  variable node being updated

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset applies immediately in any state and abandons the codeword; the datapath is not notified.
- All outputs are registered. At most one of ld_en, cn_en, vn_en is high in any cycle.
- States:
  - IDLE: if start=1, go to LOAD; clear success, iter_count and the syndrome accumulator.
  - LOAD: N cycles, ld_en=1, ld_addr counts 0..N-1, then go to CHECK.
  - CHECK: M cycles, cn_en=1, cn_addr counts 0..M-1. Each cycle, syn_acc |= chk_par, sampled in the same cycle as cn_en. After the last cycle, go to EVAL.
  - EVAL: 1 cycle, no strobes. Decision:
    - syn_acc=0 and EARLY_TERM_EN defined: success=1, go to DONE.
    - Otherwise, if iter_count==MAX_ITER: success=~syn_acc, go to DONE.
    - Otherwise go to VAR.
    - syn_acc is cleared on leaving EVAL.
  - VAR: N cycles, vn_en=1, vn_addr counts 0..N-1. On the last cycle iter_count increments; then go to CHECK.
  - DONE: done=1 for one cycle, busy=1, then go to IDLE.
- start while busy is ignored, not queued. start in the cycle DONE returns to IDLE is also ignored; it must be sampled in IDLE.
- Address counters reset to 0 on every sweep entry. No wrap past N-1 or M-1.
- iter_count never exceeds MAX_ITER. The counter is sized to hold MAX_ITER, so no wrap.
- Latency, start high in cycle 0:
  - First strobe in cycle 1.
  - Worst case, done in cycle N + MAX_ITER*(M+1+N) + (M+1) + 1.
  - Early exit after k VAR sweeps: done in cycle N + k*(M+1+N) + M + 2.

Optional Feature:
- Macro: LDPC_EARLY_TERM_EN.
- Defined: decoding terminates at the first EVAL with a zero syndrome, including before any VAR sweep (iter_count=0).
- Undefined: a zero syndrome never terminates early; exactly MAX_ITER VAR sweeps always run. success is taken from the final EVAL only, giving deterministic latency.

Decomposition:
- Shared package ldpc_pkg holds:
  - code constants N, M, LOG2N, LOG2M, MAX_ITER, LOG2MAX_ITER
  - state enum: IDLE, LOAD, CHECK, EVAL, VAR, DONE
- One natural sub-module, ldpc_sweep_cnt: a parameterised count-to-limit counter with start, en, addr and last outputs.
  - Instantiated for the LOAD/VAR sweeps (limit N) and the CHECK sweep (limit M).

Test Plan:
Directed tests use N=8, M=4, MAX_ITER=3, start pulsed in cycle 0.
- chk_par held 0, EARLY_TERM_EN defined → ld_en cycles 1-8 (addr 0..7), cn_en cycles 9-12, done in cycle 14; success=1, iter_count=0.
- chk_par held 1, macro either way → VAR sweeps in cycles 14-21, 27-34 and 40-47; done in cycle 53; success=0, iter_count=3.
- chk_par=1 only while cycle <25, EARLY_TERM_EN defined → exit at EVAL in cycle 39; done in cycle 40; success=1, iter_count=2.
- Same stimulus, macro undefined → done in cycle 53; success=1, iter_count=3.
- start re-pulsed in cycles 5 and 30 → ignored, and the timing matches the unaborted run. Check that ld_en, cn_en and vn_en are never high together.
- rst asserted in cycle 20 (mid-VAR) → all outputs 0 immediately. A new start afterwards reproduces the first-scenario timing relative to the new start.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared code constants and FSM state encoding for the LDPC iteration scheduler.
package ldpc_pkg;
    localparam int N            = 204;
    localparam int M            = 102;
    localparam int LOG2N        = 8;
    localparam int LOG2M        = 7;
    localparam int MAX_ITER     = 30;
    localparam int LOG2MAX_ITER = 5;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t CHECK = 3'd2;
    localparam state_t EVAL  = 3'd3;
    localparam state_t VAR   = 3'd4;
    localparam state_t DONE  = 3'd5;
endpackage

// File: rtl/ldpc_sweep_cnt.sv
// ldpc_sweep_cnt: self-running 0..LIMIT-1 address sweep with registered strobe and address.
module ldpc_sweep_cnt #(
    parameter int LIMIT = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         en,
    output logic [W-1:0] addr,
    output logic         last
);
    assign last = en && addr == W'(LIMIT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            en   <= 1'b0;
            addr <= '0;
        end else if (start) begin
            en   <= 1'b1;
            addr <= '0;
        end else if (last) begin
            en   <= 1'b0;
            addr <= '0;
        end else if (en)
            addr <= addr + 1'b1;
endmodule

// File: rtl/ldpc_iter_sched.sv
// ldpc_iter_sched: flooding-schedule controller for the LDPC decoder datapath.
// Optional early termination on zero syndrome: define LDPC_EARLY_TERM_EN.
module ldpc_iter_sched #(
    parameter int N            = ldpc_pkg::N,
    parameter int M            = ldpc_pkg::M,
    parameter int LOG2N        = ldpc_pkg::LOG2N,
    parameter int LOG2M        = ldpc_pkg::LOG2M,
    parameter int MAX_ITER     = ldpc_pkg::MAX_ITER,
    parameter int LOG2MAX_ITER = ldpc_pkg::LOG2MAX_ITER
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    chk_par,
    output logic                    busy,
    output logic                    done,
    output logic                    success,
    output logic [LOG2MAX_ITER-1:0] iter_count,
    output logic                    ld_en,
    output logic [LOG2N-1:0]        ld_addr,
    output logic                    cn_en,
    output logic [LOG2M-1:0]        cn_addr,
    output logic                    vn_en,
    output logic [LOG2N-1:0]        vn_addr
);
    import ldpc_pkg::*;
    state_t state, nxt;
    logic   syn_acc, term, ld_go, cn_go, vn_go, ld_last, cn_last, vn_last;
`ifdef LDPC_EARLY_TERM_EN
    assign term = !syn_acc || iter_count == LOG2MAX_ITER'(MAX_ITER);
`else
    assign term = iter_count == LOG2MAX_ITER'(MAX_ITER);
`endif
    assign ld_go = state == IDLE && start;
    assign cn_go = (state == LOAD && ld_last) || (state == VAR && vn_last);
    assign vn_go = state == EVAL && !term;
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = ld_last ? CHECK : LOAD;
            CHECK:   nxt = cn_last ? EVAL : CHECK;
            EVAL:    nxt = term ? DONE : VAR;
            VAR:     nxt = vn_last ? CHECK : VAR;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            iter_count <= '0;
            syn_acc    <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= nxt != IDLE;
            done  <= nxt == DONE;
            if (ld_go) begin
                success    <= 1'b0;
                iter_count <= '0;
                syn_acc    <= 1'b0;
            end
            if (state == CHECK)
                syn_acc <= syn_acc | chk_par;
            if (state == EVAL) begin
                syn_acc <= 1'b0;
                if (term)
                    success <= ~syn_acc;
            end
            if (state == VAR && vn_last)
                iter_count <= iter_count + 1'b1;
        end
    // Each sweep owns its strobe/address so all outputs come straight from flops.
    ldpc_sweep_cnt #(.LIMIT(N), .W(LOG2N)) u_ld (
        .clk(clk), .rst(rst), .start(ld_go), .en(ld_en), .addr(ld_addr), .last(ld_last)
    );
    ldpc_sweep_cnt #(.LIMIT(M), .W(LOG2M)) u_cn (
        .clk(clk), .rst(rst), .start(cn_go), .en(cn_en), .addr(cn_addr), .last(cn_last)
    );
    ldpc_sweep_cnt #(.LIMIT(N), .W(LOG2N)) u_vn (
        .clk(clk), .rst(rst), .start(vn_go), .en(vn_en), .addr(vn_addr), .last(vn_last)
    );
endmodule

// File: tb/tb_ldpc_iter_sched.sv
// tb_ldpc_iter_sched: directed table plus randomized runs against a schedule-level reference model.
module tb_ldpc_iter_sched;
    localparam int N = 8, M = 4, MAX_ITER = 3, LEN = 60;
`ifdef LDPC_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, chk_par = 1'b0;
    logic busy, done, success, ld_en, cn_en, vn_en;
    logic [1:0] iter_count, cn_addr;
    logic [2:0] ld_addr, vn_addr;
    ldpc_iter_sched #(.N(N), .M(M), .LOG2N(3), .LOG2M(2), .MAX_ITER(MAX_ITER), .LOG2MAX_ITER(2)) dut (
        .clk(clk), .rst(rst), .start(start), .chk_par(chk_par), .busy(busy), .done(done),
        .success(success), .iter_count(iter_count), .ld_en(ld_en), .ld_addr(ld_addr),
        .cn_en(cn_en), .cn_addr(cn_addr), .vn_en(vn_en), .vn_addr(vn_addr)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    bit par_v[LEN];
    int e_ld[LEN], e_lda[LEN], e_cn[LEN], e_cna[LEN], e_vn[LEN], e_vna[LEN];
    int e_busy[LEN], e_done[LEN], e_succ[LEN], e_iter[LEN];
    int prev_succ = 0, prev_iter = 0, m_done, obs_done, obs_succ, obs_iter;
    typedef struct {int mode; bit rep; int rst_at; int x_done; int x_succ; int x_iter;} row_t;
    row_t tbl[6];
    task automatic chk(input string nm, input int c, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, c, act, exp);
        end
    endtask
    // Schedule model: load, then repeated {check sweep, eval, var sweep} with decisions from the syndrome.
    task automatic build();
        int t, it, vend[$];
        bit s;
        for (int c = 0; c < LEN; c++) begin
            e_ld[c] = 0; e_lda[c] = 0; e_cn[c] = 0; e_cna[c] = 0; e_vn[c] = 0; e_vna[c] = 0;
        end
        t = 1; it = 0;
        for (int a = 0; a < N; a++) begin e_ld[t] = 1; e_lda[t] = a; t++; end
        forever begin
            s = 0;
            for (int a = 0; a < M; a++) begin e_cn[t] = 1; e_cna[t] = a; s |= par_v[t]; t++; end
            t++;
            if ((ET && !s) || it == MAX_ITER) break;
            for (int a = 0; a < N; a++) begin e_vn[t] = 1; e_vna[t] = a; t++; end
            vend.push_back(t - 1);
            it++;
        end
        m_done = t;
        for (int c = 1; c < LEN; c++) begin
            e_busy[c] = int'(c <= m_done);
            e_done[c] = int'(c == m_done);
            e_succ[c] = (c >= m_done) ? int'(!s) : 0;
            e_iter[c] = 0;
            foreach (vend[i]) if (vend[i] < c) e_iter[c]++;
        end
        e_busy[0] = 0; e_done[0] = 0; e_succ[0] = prev_succ; e_iter[0] = prev_iter;
    endtask
    task automatic cmp_cycle(input int c);
        chk("ld_en", c, ld_en, e_ld[c]);       chk("ld_addr", c, ld_addr, e_lda[c]);
        chk("cn_en", c, cn_en, e_cn[c]);       chk("cn_addr", c, cn_addr, e_cna[c]);
        chk("vn_en", c, vn_en, e_vn[c]);       chk("vn_addr", c, vn_addr, e_vna[c]);
        chk("busy", c, busy, e_busy[c]);       chk("done", c, done, e_done[c]);
        chk("success", c, success, e_succ[c]); chk("iter_count", c, iter_count, e_iter[c]);
        chk("one_hot_strobes", c, int'(ld_en) + int'(cn_en) + int'(vn_en) <= 1, 1);
        if (done) begin obs_done = c; obs_succ = success; obs_iter = iter_count; end
    endtask
    task automatic zeros_now();
        chk("rst_busy", -1, busy, 0);   chk("rst_done", -1, done, 0);
        chk("rst_success", -1, success, 0); chk("rst_iter", -1, iter_count, 0);
        chk("rst_strobes", -1, {ld_en, cn_en, vn_en}, 0);
        chk("rst_addrs", -1, {ld_addr, cn_addr, vn_addr}, 0);
    endtask
    task automatic run(input bit rep, input int rst_at);
        build();
        obs_done = -1; obs_succ = -1; obs_iter = -1;
        for (int c = 0; c < LEN; c++) begin
            @(negedge clk);
            cmp_cycle(c);
            if (c == rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                #1 zeros_now();
                @(negedge clk);
                zeros_now();
                rst = 1'b0;
                prev_succ = 0; prev_iter = 0;
                return;
            end
            start = c == 0 || (rep && (c == 5 || c == 30 || c == m_done));
            chk_par = par_v[c];
        end
        start = 1'b0;
        prev_succ = e_succ[LEN-1]; prev_iter = e_iter[LEN-1];
    endtask
    initial begin
        tbl[0] = '{0, 1'b0, -1, ET ? 14 : 53, 1, ET ? 0 : 3};
        tbl[1] = '{1, 1'b0, -1, 53, 0, 3};
        tbl[2] = '{2, 1'b0, -1, ET ? 40 : 53, 1, ET ? 2 : 3};
        tbl[3] = '{1, 1'b1, -1, 53, 0, 3};
        tbl[4] = '{1, 1'b0, 20, 0, 0, 0};
        tbl[5] = '{0, 1'b0, -1, ET ? 14 : 53, 1, ET ? 0 : 3};
        #2 zeros_now();
        @(negedge clk);
        rst = 1'b0;
        foreach (tbl[r]) begin
            for (int c = 0; c < LEN; c++)
                par_v[c] = tbl[r].mode == 1 || (tbl[r].mode == 2 && c < 25);
            run(tbl[r].rep, tbl[r].rst_at);
            if (tbl[r].rst_at < 0) begin
                chk("tbl_done_cycle", r, obs_done, tbl[r].x_done);
                chk("tbl_success", r, obs_succ, tbl[r].x_succ);
                chk("tbl_iter", r, obs_iter, tbl[r].x_iter);
            end
        end
        for (int r = 0; r < 20; r++) begin
            int dens;
            dens = $urandom_range(1, 40);
            for (int c = 0; c < LEN; c++) par_v[c] = $urandom_range(0, dens) == 0;
            run(1'b0, -1);
            chk("rnd_done_cycle", r, obs_done, m_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
